// File: rtl/otter_pipe_ctrl_if.sv
// Handshake/bus bundle between the OTTER datapath and its hazard controller.
// Latency: none, wires only.
// Backpressure: carries mem_busy (freeze) and the stall/flush controls back to the datapath.
// master: datapath side (drives DE fields, redirect, mem_busy; receives controls)
// slave : controller side (otter_pipe_ctrl)
interface otter_pipe_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             de_valid;
    logic [4:0]       de_rs1_addr;
    logic [4:0]       de_rs2_addr;
    logic             de_rs1_used;
    logic             de_rs2_used;
    logic [4:0]       de_rd_addr;
    logic             de_reg_write;
    logic             de_is_load;
    logic             ex_redirect;
    logic             mem_busy;
    logic             pc_write;
    logic             de_hold;
    logic             ex_bubble;
    logic             de_flush;
    logic             stage_en;
    logic [1:0]       fwd_a_sel;
    logic [1:0]       fwd_b_sel;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output de_valid, de_rs1_addr, de_rs2_addr, de_rs1_used, de_rs2_used,
               de_rd_addr, de_reg_write, de_is_load, ex_redirect, mem_busy,
        input  pc_write, de_hold, ex_bubble, de_flush, stage_en,
               fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );

    modport slave (
        input  de_valid, de_rs1_addr, de_rs2_addr, de_rs1_used, de_rs2_used,
               de_rd_addr, de_reg_write, de_is_load, ex_redirect, mem_busy,
        output pc_write, de_hold, ex_bubble, de_flush, stage_en,
               fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/otter_pipe_ctrl.sv
// Hazard/sequencing controller for the 5-stage OTTER pipeline (shadow scoreboard of EX/MEM/WB).
// Latency: all controls and forwarding selects are combinational from shadow state and inputs.
// Backpressure: mem_busy freezes PC, stage registers, shadow and counters; load-use holds DE one cycle.
// Ports: CLK, RESET (async, active-high), bus (slave modport): DE register-use fields,
//        ex_redirect, mem_busy in; pc_write, de_hold, ex_bubble, de_flush, stage_en,
//        fwd_a_sel, fwd_b_sel, stall_cnt, flush_cnt out.
module otter_pipe_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic          CLK,
    input  logic          RESET,
    otter_pipe_ctrl_if.slave bus
);
    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       is_load;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       rs1_used;
        logic       rs2_used;
    } stage_t;

    localparam stage_t STAGE_EMPTY = '0;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    stage_t           r_ex, r_mem, r_wb;
    logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;

    stage_t w_de_rec;
    logic   w_ex_writes, w_lu, w_rd_eff;
    logic   w_pc_write, w_de_hold, w_ex_bubble, w_de_flush, w_stage_en;
    logic   w_take_lu, w_take_rd;

    function automatic logic writes_rd(input stage_t s);
        return s.valid && s.reg_write && (s.rd != 5'd0);
    endfunction

    // MEM wins over WB. A MEM load match cannot occur (load-use stalls first);
    // if it does, fall back to the register file rather than a stale WB value.
    function automatic logic [1:0] fwd_sel(input stage_t ex, input stage_t mem, input stage_t wb,
                                           input logic [4:0] rs, input logic used);
        logic [1:0] sel;
        sel = 2'd0;
        if (ex.valid && used) begin
            if (writes_rd(mem) && mem.rd == rs) begin
                sel = mem.is_load ? 2'd0 : 2'd1;
            end else if (writes_rd(wb) && wb.rd == rs) begin
                sel = 2'd2;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_de_rec          = STAGE_EMPTY;
        w_de_rec.valid    = bus.de_valid;
        w_de_rec.rd       = bus.de_rd_addr;
        w_de_rec.reg_write = bus.de_reg_write;
        w_de_rec.is_load  = bus.de_is_load;
        w_de_rec.rs1      = bus.de_rs1_addr;
        w_de_rec.rs2      = bus.de_rs2_addr;
        w_de_rec.rs1_used = bus.de_rs1_used;
        w_de_rec.rs2_used = bus.de_rs2_used;
    end

    // rd != 0 inside writes_rd also keeps x0 sources from ever hazarding.
    assign w_ex_writes = writes_rd(r_ex);
    assign w_lu = w_ex_writes && r_ex.is_load && bus.de_valid &&
                  ((bus.de_rs1_used && bus.de_rs1_addr == r_ex.rd) ||
                   (bus.de_rs2_used && bus.de_rs2_addr == r_ex.rd));
    assign w_rd_eff = bus.ex_redirect && r_ex.valid;

    always_comb begin
        w_pc_write  = 1'b1;
        w_stage_en  = 1'b1;
        w_de_hold   = 1'b0;
        w_ex_bubble = 1'b0;
        w_de_flush  = 1'b0;
        w_take_lu   = 1'b0;
        w_take_rd   = 1'b0;
        if (RESET) begin
            // hold the free-running defaults while reset is asserted
        end else if (bus.mem_busy) begin
            w_pc_write = 1'b0;
            w_stage_en = 1'b0;
            w_de_hold  = 1'b1;
        end else if (w_rd_eff) begin
            // DE is killed, so a simultaneous load-use is moot
            w_de_flush  = 1'b1;
            w_ex_bubble = 1'b1;
            w_take_rd   = 1'b1;
        end else if (w_lu) begin
            w_pc_write  = 1'b0;
            w_de_hold   = 1'b1;
            w_ex_bubble = 1'b1;
            w_take_lu   = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_ex        <= STAGE_EMPTY;
            r_mem       <= STAGE_EMPTY;
            r_wb        <= STAGE_EMPTY;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (!bus.mem_busy) begin
            r_wb  <= r_mem;
            r_mem <= r_ex;
            if (w_ex_bubble) begin
                r_ex <= STAGE_EMPTY;
            end else begin
                r_ex <= w_de_rec;
            end
            if (w_take_lu && r_stall_cnt != '1) begin
                r_stall_cnt <= r_stall_cnt + CNT_ONE;
            end
            if (w_take_rd && r_flush_cnt != '1) begin
                r_flush_cnt <= r_flush_cnt + CNT_ONE;
            end
        end
    end

    assign bus.pc_write  = w_pc_write;
    assign bus.de_hold   = w_de_hold;
    assign bus.ex_bubble = w_ex_bubble;
    assign bus.de_flush  = w_de_flush;
    assign bus.stage_en  = w_stage_en;
    assign bus.fwd_a_sel = fwd_sel(r_ex, r_mem, r_wb, r_ex.rs1, r_ex.rs1_used);
    assign bus.fwd_b_sel = fwd_sel(r_ex, r_mem, r_wb, r_ex.rs2, r_ex.rs2_used);
    assign bus.stall_cnt = r_stall_cnt;
    assign bus.flush_cnt = r_flush_cnt;
endmodule

// File: doc/otter_pipe_ctrl.md
Name: otter_pipe_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage OTTER pipeline (IF, DE, EX, MEM, WB).
- Keeps a shadow scoreboard of the register-use fields of the instructions in EX, MEM and WB.
- From the scoreboard it drives PC/stage enables, bubble insertion, the DE flush and the ALU operand forwarding selects.
- It replaces the hardwired pcWrite=1 / memRead1=1 and counts stall and flush events for performance monitoring.

Parameters:
CNT_W, 16, width of the saturating stall and flush event counters

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-high reset
de_valid  in  1  DE holds a real instruction
de_rs1_addr  in  5  DE rs1 field
de_rs2_addr  in  5  DE rs2 field
de_rs1_used  in  1  DE instruction reads rs1
de_rs2_used  in  1  DE instruction reads rs2
de_rd_addr  in  5  DE rd field
de_reg_write  in  1  DE instruction writes rd
de_is_load  in  1  DE instruction is LOAD
ex_redirect  in  1  EX resolved a taken branch/JAL/JALR; PC mux selects the target
mem_busy  in  1  data memory not ready; freeze whole pipeline
pc_write  out  1  PC load enable
de_hold  out  1  hold IR/DE contents
ex_bubble  out  1  load a NOP (all write enables 0) into EX
de_flush  out  1  kill the instruction in DE
stage_en  out  1  enable for DE/EX, EX/MEM and MEM/WB pipeline registers
fwd_a_sel  out  2  EX operand A source: 0 = RF, 1 = MEM ALU result, 2 = WB rfIn
fwd_b_sel  out  2  EX operand B / rs2 source, same encoding
stall_cnt  out  CNT_W  load-use stall cycles
flush_cnt  out  CNT_W  redirects taken

Behaviour:
- Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
- Reset effects: clears all shadow valid bits and both counters. While RESET is asserted and after it releases, outputs are pc_write=1, stage_en=1, de_hold=0, ex_bubble=0, de_flush=0, fwd_*=0, counters 0.
- Shadow stage record (EX, MEM, WB): valid, rd, reg_write, is_load, rs1, rs2, rs1_used, rs2_used.
- Stage "writes rd" = valid && reg_write && rd!=0.
- Load-use hazard (lu):
  - Condition: EX writes rd, EX.is_load, de_valid, and (de_rs1_used && de_rs1_addr==EX.rd, or de_rs2_used && de_rs2_addr==EX.rd).
  - rs==x0 never hazards.
- Effective redirect (rd_eff) = ex_redirect && EX.valid.
- Output priority, evaluated combinationally from current shadow state and inputs:
  1. mem_busy: pc_write=0, stage_en=0, de_hold=1, ex_bubble=0, de_flush=0. Shadow does not advance, counters hold, and a pending redirect or lu is re-evaluated next cycle.
  2. rd_eff: pc_write=1, stage_en=1, de_flush=1, ex_bubble=1, de_hold=0. An lu in the same cycle is ignored because the DE instruction is killed.
  3. lu: pc_write=0, de_hold=1, ex_bubble=1, stage_en=1, de_flush=0.
  4. Otherwise: pc_write=1, stage_en=1, all others 0.
- Shadow update on the clock edge when mem_busy=0:
  - WB<=MEM, MEM<=EX.
  - EX<= DE fields with valid=de_valid, or valid=0 if ex_bubble.
- Forwarding (combinational, for the instruction in EX):
  - fwd_a_sel=1 if EX.valid && EX.rs1_used && MEM writes rd && MEM.rd==EX.rs1 && !MEM.is_load.
  - Else fwd_a_sel=2 if the same holds against WB (loads allowed from WB).
  - Else 0. MEM has priority over WB.
  - fwd_b_sel uses rs2 with identical rules.
  - MEM.is_load matching is impossible by construction (lu stalls 1 cycle, then the load reaches WB); select 0 if it occurs.
- Counters:
  - stall_cnt +1 each edge where the lu outcome is taken (priority 3).
  - flush_cnt +1 each edge where the rd_eff outcome is taken (priority 2).
  - Both saturate at 2^CNT_W-1 and do not count while mem_busy.
- Timing: no output latency beyond combinational logic; exactly one bubble per load-use; two squashed slots per redirect (DE instruction flushed, EX bubble).

Test Plan:
- Independent ops: ADD x1; ADD x2; ADD x3 with no shared regs -> pc_write=1 every cycle, fwd=0, stall_cnt=0, flush_cnt=0.
- Back-to-back dependency: ADD x5,x1,x2 then SUB x6,x5,x3 -> when SUB is in EX, fwd_a_sel=1. With one NOP between them, fwd_a_sel=2. With rd=x0 instead of x5, fwd_a_sel=0.
- Load-use: LW x7 then ADD x8,x7,x7 -> exactly one cycle of pc_write=0, de_hold=1, ex_bubble=1. Then ADD in EX with fwd_a_sel=fwd_b_sel=2. stall_cnt=1.
- Taken branch with a load-use dependency in DE in the same cycle -> de_flush=1, ex_bubble=1, pc_write=1, no stall. flush_cnt=1, stall_cnt=0.
- mem_busy held 3 cycles during a pending lu -> stage_en=0 and pc_write=0 for 3 cycles with counters frozen. After release, one lu stall cycle and stall_cnt=1.
- RESET pulsed asynchronously mid-stall (between clock edges) -> outputs return immediately to reset values, counters=0, no forwarding from stale shadow entries on the first post-reset instructions. With CNT_W=4, 20 load-use stalls -> stall_cnt saturates at 15.
